fp32_mult_seq: RTL and testbench
================================

# fp32_mult_seq

Multi-cycle IEEE-754 single-precision multiplier with a start/done handshake. It consumes the two 32-bit operands assembled byte-by-byte by the operand-entry FSM and returns the 32-bit product plus exception flags for the byte-wise 7-segment result display. It replaces the combinational multiplier path with a shift-add mantissa datapath, which trades latency for area and timing margin.

## Interface
- `BITS_PER_CYCLE`, default 1: mantissa multiplier bits consumed per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8, 12 and 24 (divisors of 24). Define `M = 24 / BITS_PER_CYCLE`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `a`  in  32  operand A (IEEE-754 single); latched when start is accepted
- `b`  in  32  operand B; latched when start is accepted
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse; result and flags are valid in this cycle
- `result`  out  32  product; held until the next done
- `ovf`  out  1  overflow to infinity; held with result
- `unf`  out  1  underflow flushed to zero; held with result
- `nan`  out  1  invalid or NaN result; held with result

## Operation
- States and transitions:
  - IDLE → UNPACK when `start` is high.
  - UNPACK → MUL.
  - MUL stays for M cycles, then → NORM.
  - NORM → ROUND.
  - ROUND → IDLE. On this transition `result`, the flags and `done` are registered.
- UNPACK:
  - sign = a[31] XOR b[31].
  - exp_sum = ea + eb − 127, in a 10-bit signed register.
  - Significands are {1, frac}. Any input with exponent 0 (zero or denormal) is treated as zero (flush-to-zero).
  - Special cases are classified here. Specials still traverse all states, so latency is fixed.
- MUL: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 48-bit product register, LSB first.
- NORM:
  - If prod[47] = 1: mantissa = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp_sum += 1.
  - Otherwise: mantissa = prod[45:23], guard = prod[22], sticky = |prod[21:0].
- ROUND: round-to-nearest-even. Increment when guard & (sticky | lsb). A mantissa carry-out sets mantissa to 0 and adds 1 to exp_sum.
- Final exponent checks, after rounding:
  - ≥ 255: result = {sign, 8'hFF, 23'h0}, ovf = 1.
  - ≤ 0: result = {sign, 31'h0}, unf = 1.
- Special-case priority, which overrides the datapath:
  1. Any NaN input, or inf × zero: result = 32'h7FC0_0000, nan = 1.
  2. inf × nonzero: signed infinity, no flags.
  3. zero × finite: signed zero, no flags.
- At most one flag is set per result. Flags are cleared and re-evaluated at every done.

## Timing
- Cycle numbering:
  - Edge E0 samples `start` = 1 in IDLE and latches `a`/`b`.
  - `busy` rises after E0.
  - `result`, flags and `done` update at edge E(M+3). `done` is high for exactly that one cycle and `busy` is low in the same cycle.
  - Latency is M+3 cycles: 27 cycles for BITS_PER_CYCLE = 1, 4 cycles for 24.
- `start` while busy is ignored. Operands are not re-latched and no extra done is produced.
- `start` held high in the done cycle is accepted, giving back-to-back operation with one IDLE cycle per operation.
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `ovf`/`unf`/`nan` = 0, state = IDLE.
- Reset mid-operation aborts immediately. No done pulse follows, and the old result is cleared.
- `result`/flags are stable from done until the next done. They do not change when `a`/`b` change.

## Test plan
- 0x40400000 × 0x40000000 (3.0 × 2.0) → result 0x40C00000, done exactly M+3 cycles after start, flags 0. Also 0x3FC00000 × 0xBFC00000 → 0xC0100000 (sign by XOR).
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002 (ties/sticky path). Also 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE (prod[47] normalization).
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000, ovf = 1.
  - 0x00800000 × 0x3F000000 → 0x00000000, unf = 1.
  - 0x80800000 × 0x3F000000 → 0x80000000, unf = 1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, nan = 1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, no flags.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, nan = 1.
- Handshake:
  - Pulse start again 5 cycles into an operation with different operands → ignored, single done with the original product.
  - Hold start high continuously → a done every M+4 cycles.
- Assert reset at MUL cycle 3 → busy/done/result/flags go to 0 immediately. No done until a new start. The next operation is correct.

Source files
------------

// File: rtl/fp32_mult_seq.sv
// fp32_mult_seq: multi-cycle IEEE-754 single-precision multiplier.
// Operands are latched on start, multiplied by a shift-add datapath that
// consumes BITS_PER_CYCLE multiplier bits per cycle, then normalised and
// rounded to nearest-even. Denormal inputs are flushed to zero, and
// underflowing results are flushed to zero. Latency is fixed at M+3 cycles.
module fp32_mult_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        nan
);

    localparam int unsigned M = 24 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t          state, state_nxt;
    logic [4:0]      cnt;
    logic [31:0]     a_r, b_r;
    logic            sign_r;
    logic signed [9:0] exp_r;
    logic [47:0]     mcand_r;
    logic [23:0]     mplier_r;
    logic [47:0]     prod_r;
    logic [22:0]     mant_r;
    logic            guard_r, sticky_r;
    special_t        special_r;

    // unpack-stage decode
    logic [7:0]      ea_u, eb_u;
    logic [22:0]     fa_u, fb_u;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    special_t        special_u;

    // shift-add step
    logic [47:0]     partial;

    // rounding stage
    logic            inc;
    logic [23:0]     mant_inc;
    logic signed [9:0] exp_fin;
    logic [31:0]     res_nxt;
    logic            ovf_nxt, unf_nxt, nan_nxt;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = MUL;
            MUL:     if (cnt == 5'(M - 1)) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand field decode and special-case classification
    always_comb begin
        ea_u   = a_r[30:23];
        eb_u   = b_r[30:23];
        fa_u   = a_r[22:0];
        fb_u   = b_r[22:0];
        a_nan  = (&ea_u) && (|fa_u);
        b_nan  = (&eb_u) && (|fb_u);
        a_inf  = (&ea_u) && !(|fa_u);
        b_inf  = (&eb_u) && !(|fb_u);
        a_zero = (ea_u == 8'h00);
        b_zero = (eb_u == 8'h00);
        special_u = SP_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            special_u = SP_NAN;
        else if (a_inf || b_inf)
            special_u = SP_INF;
        else if (a_zero || b_zero)
            special_u = SP_ZERO;
    end

    // Sum of the multiplicand copies selected by this cycle's multiplier bits
    always_comb begin
        logic [23:0] mb;
        partial = '0;
        mb      = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            mb = mplier_r >> i;
            if (mb[0]) partial = partial + (mcand_r << i);
        end
    end

    // Round to nearest-even, final exponent range check and special override
    always_comb begin
        inc      = guard_r & (sticky_r | mant_r[0]);
        mant_inc = {1'b0, mant_r} + {23'b0, inc};
        exp_fin  = exp_r + $signed({9'b0, mant_inc[23]});
        res_nxt  = {sign_r, exp_fin[7:0], mant_inc[22:0]};
        ovf_nxt  = 1'b0;
        unf_nxt  = 1'b0;
        nan_nxt  = 1'b0;
        case (special_r)
            SP_NAN: begin
                res_nxt = 32'h7FC0_0000;
                nan_nxt = 1'b1;
            end
            SP_INF:  res_nxt = {sign_r, 8'hFF, 23'h0};
            SP_ZERO: res_nxt = {sign_r, 31'h0};
            default: begin
                if (exp_fin >= 10'sd255) begin
                    res_nxt = {sign_r, 8'hFF, 23'h0};
                    ovf_nxt = 1'b1;
                end else if (exp_fin <= 10'sd0) begin
                    res_nxt = {sign_r, 31'h0};
                    unf_nxt = 1'b1;
                end
            end
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            prod_r    <= '0;
            mant_r    <= '0;
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
            special_r <= SP_NONE;
            done      <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            nan       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                UNPACK: begin
                    sign_r    <= a_r[31] ^ b_r[31];
                    exp_r     <= $signed({2'b00, ea_u}) + $signed({2'b00, eb_u}) - 10'sd127;
                    mcand_r   <= {24'b0, (a_zero ? 24'h0 : {1'b1, fa_u})};
                    mplier_r  <= b_zero ? 24'h0 : {1'b1, fb_u};
                    prod_r    <= '0;
                    special_r <= special_u;
                    cnt       <= '0;
                end
                MUL: begin
                    prod_r   <= prod_r + partial;
                    mcand_r  <= mcand_r << BITS_PER_CYCLE;
                    mplier_r <= mplier_r >> BITS_PER_CYCLE;
                    cnt      <= cnt + 5'd1;
                end
                NORM: begin
                    if (prod_r[47]) begin
                        mant_r   <= prod_r[46:24];
                        guard_r  <= prod_r[23];
                        sticky_r <= |prod_r[22:0];
                        exp_r    <= exp_r + 10'sd1;
                    end else begin
                        mant_r   <= prod_r[45:23];
                        guard_r  <= prod_r[22];
                        sticky_r <= |prod_r[21:0];
                    end
                end
                ROUND: begin
                    result <= res_nxt;
                    ovf    <= ovf_nxt;
                    unf    <= unf_nxt;
                    nan    <= nan_nxt;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mult_seq.sv
// Scoreboard bench for fp32_mult_seq: directed vectors, handshake corner
// cases, mid-operation reset and randomized operands against an
// integer-arithmetic reference model.
module tb_fp32_mult_seq;

    localparam int unsigned BPC = 2;
    localparam int unsigned M   = 24 / BPC;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, ovf, unf, nan;
    logic [31:0] result;

    fp32_mult_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .ovf(ovf), .unf(unf), .nan(nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf, nan;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_res = '0;
    logic [2:0]  last_flags = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: exact integer product, then RNE with flush-to-zero
    function automatic exp_t ref_mul(input logic [31:0] x, input logic [31:0] y);
        exp_t   r;
        int     ex, ey, e, sh;
        logic   s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        longint p, m, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        x_nan  = (ex == 255) && (x[22:0] != 0);
        y_nan  = (ey == 255) && (y[22:0] != 0);
        x_inf  = (ex == 255) && (x[22:0] == 0);
        y_inf  = (ey == 255) && (y[22:0] == 0);
        x_zero = (ex == 0);
        y_zero = (ey == 0);
        r.ovf = 0; r.unf = 0; r.nan = 0; r.acc = 0;
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            r.res = 32'h7FC00000; r.nan = 1;
        end else if (x_inf || y_inf) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (x_zero || y_zero) begin
            r.res = {s, 31'h0};
        end else begin
            p = (longint'(x[22:0]) + 64'd8388608) * (longint'(y[22:0]) + 64'd8388608);
            e = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
            else sh = 23;
            m    = p >> sh;
            rem  = p - (m << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
            if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e = e + 1; end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0}; r.ovf = 1;
            end else if (e <= 0) begin
                r.res = {s, 31'h0}; r.unf = 1;
            end else begin
                r.res = {s, 8'(e), 23'(m)};
            end
        end
        return r;
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done result=%h", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(result), 64'(mon_e.res));
                check("flags_ovf_unf_nan", 64'({ovf, unf, nan}), 64'({mon_e.ovf, mon_e.unf, mon_e.nan}));
                check("latency", 64'(cyc - mon_e.acc), 64'(M + 3));
                check("busy_at_done", 64'(busy), 64'(0));
                last_res   = mon_e.res;
                last_flags = {mon_e.ovf, mon_e.unf, mon_e.nan};
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, output int acc);
        @(negedge clk);
        wait_idle();
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input exp_t e);
        int acc;
        issue(x, y, acc);
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic send_model(input logic [31:0] x, input logic [31:0] y);
        send(x, y, ref_mul(x, y));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 15))
            0:  return {s, 31'h0};
            1:  return {s, 8'hFF, 23'h0};
            2:  return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
            3:  return {s, 8'h00, 23'($urandom)};
            4:  return $urandom;
            5:  return {s, 8'($urandom_range(100, 154)), 23'h7FFFFF};
            default: return {s, 8'($urandom_range(64, 190)), 23'($urandom)};
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic [2:0] f);
        exp_t e;
        e.res = r; e.ovf = f[2]; e.unf = f[1]; e.nan = f[0]; e.acc = 0;
        return e;
    endfunction

    logic [31:0] dir_a[10] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                               32'h00800000, 32'h80800000, 32'h7F800000, 32'hFF800000, 32'h7FC00001};
    logic [31:0] dir_b[10] = '{32'h40000000, 32'hBFC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h40000000,
                               32'h3F000000, 32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F800000};
    logic [31:0] dir_r[10] = '{32'h40C00000, 32'hC0100000, 32'h3F800002, 32'h407FFFFE, 32'h7F800000,
                               32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};
    logic [2:0]  dir_f[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                               3'b010, 3'b010, 3'b001, 3'b000, 3'b001};

    initial begin
        int c0;
        int acc;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_flags", 64'({ovf, unf, nan}), 64'(0));
        reset = 1'b0;

        // Directed vectors with hand-derived expectations
        for (int i = 0; i < 10; i++) begin
            send(dir_a[i], dir_b[i], mk(dir_r[i], dir_f[i]));
            drain();
        end

        // Result holds while operands change
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        repeat (4) @(negedge clk);
        check("result_hold", 64'(result), 64'(last_res));
        check("flags_hold", 64'({ovf, unf, nan}), 64'(last_flags));

        // start pulsed mid-operation is ignored
        send(32'h40400000, 32'h40000000, mk(32'h40C00000, 3'b000));
        repeat (4) @(negedge clk);
        a = 32'h3F800001;
        b = 32'h41200000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (M + 6) @(negedge clk);

        // start held high: back-to-back, one done every M+4 cycles
        @(negedge clk);
        wait_idle();
        a = 32'h3FC00000;
        b = 32'hBFC00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e = mk(32'hC0100000, 3'b000);
            e.acc = c0 + k * int'(M + 4);
            sb.push_back(e);
        end
        repeat (3 * (M + 4)) @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Reset during MUL aborts the operation and clears outputs
        issue(32'h40400000, 32'h40000000, acc);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_result", 64'(result), 64'(0));
        check("abort_flags", 64'({ovf, unf, nan}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (M + 8) @(negedge clk);
        send(32'h3F800001, 32'h3F800001, mk(32'h3F800002, 3'b000));
        drain();

        // Randomized operands against the reference model
        for (int i = 0; i < 250; i++) begin
            send_model(rand_fp(), rand_fp());
        end
        drain();
        repeat (M + 6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
